// File: rtl/bt_seq_alu.sv
// Balanced-ternary sequential ALU: single-cycle ADD/SUB/ACC, trit-serial MUL (one y trit per cycle).
// Optional build macro BT_SATURATE_EN clamps overflowing results to +/-max instead of wrapping.
module bt_seq_alu #(
  parameter int N_TRITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [2*N_TRITS-1:0]   x,
  input  logic [2*N_TRITS-1:0]   y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*N_TRITS-1:0]   res,
  output logic                   ovf
);

  localparam int W  = 2 * N_TRITS;
  localparam int W2 = 4 * N_TRITS;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  localparam logic [1:0] T_NEG  = 2'b01;
  localparam logic [1:0] T_ZERO = 2'b11;
  localparam logic [1:0] T_POS  = 2'b10;

  localparam logic [W-1:0]  ZERO_N    = {N_TRITS{T_ZERO}};
  localparam logic [W2-1:0] ZERO_2N   = {(2*N_TRITS){T_ZERO}};
  localparam logic [4:0]    LAST_STEP = 5'(N_TRITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int tval(input logic [1:0] t);
    case (t)
      T_NEG:   return -1;
      T_POS:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] tenc(input int v);
    if (v > 0)      return T_POS;
    else if (v < 0) return T_NEG;
    else            return T_ZERO;
  endfunction

  function automatic logic [W-1:0] tnegw(input logic [W-1:0] a);
    logic [W-1:0] r;
    r = ZERO_N;
    for (int i = 0; i < N_TRITS; i++) r[2*i +: 2] = tenc(-tval(a[2*i +: 2]));
    return r;
  endfunction

  // Scale every trit of a by a single trit (-1, 0 or +1).
  function automatic logic [W2-1:0] tscale(input logic [W2-1:0] a, input logic [1:0] t);
    logic [W2-1:0] r;
    r = ZERO_2N;
    for (int i = 0; i < 2*N_TRITS; i++) r[2*i +: 2] = tenc(tval(a[2*i +: 2]) * tval(t));
    return r;
  endfunction

  // Ripple balanced-ternary adder; operands never exceed 2N trits, so the final carry is always zero.
  function automatic logic [W2-1:0] tadd(input logic [W2-1:0] a, input logic [W2-1:0] b);
    logic [W2-1:0] r;
    int c;
    int s;
    r = ZERO_2N;
    c = 0;
    for (int i = 0; i < 2*N_TRITS; i++) begin
      s = tval(a[2*i +: 2]) + tval(b[2*i +: 2]) + c;
      if (s > 1) begin
        s = s - 3;
        c = 1;
      end else if (s < -1) begin
        s = s + 3;
        c = -1;
      end else begin
        c = 0;
      end
      r[2*i +: 2] = tenc(s);
    end
    return r;
  endfunction

  state_t        state_r, state_next;
  logic [W2-1:0] pp_r, xs_r;
  logic [W-1:0]  y_r, acc_r, res_r;
  logic [4:0]    step_r;
  logic          out_valid_r, ovf_r;

  logic [W2-1:0] add_a, add_b, term_s, wide_s;
  logic [W-1:0]  res_s;
  logic          ovf_s;
`ifdef BT_SATURATE_EN
  logic          pos_s;
`endif

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign res       = res_r;
  assign ovf       = ovf_r;

  assign term_s = tscale(xs_r, y_r[1:0]);
  assign wide_s = tadd(add_a, add_b);

  // Shared adder operand selection: MUL accumulation or the single-cycle ops.
  always_comb begin
    add_a = {ZERO_N, x};
    add_b = {ZERO_N, y};
    case (state_r)
      MUL_RUN: begin
        add_a = pp_r;
        add_b = term_s;
      end
      default: begin
        case (op)
          OP_SUB:  add_b = {ZERO_N, tnegw(y)};
          OP_ACC: begin
            add_a = {ZERO_N, acc_r};
            add_b = {ZERO_N, x};
          end
          default: add_b = {ZERO_N, y};
        endcase
      end
    endcase
  end

  // Overflow is any non-zero trit above the low N; the sign of the true result is its top non-zero trit.
  always_comb begin
    ovf_s = 1'b0;
    for (int i = N_TRITS; i < 2*N_TRITS; i++) ovf_s = ovf_s | (wide_s[2*i +: 2] != T_ZERO);
`ifdef BT_SATURATE_EN
    pos_s = 1'b0;
    for (int i = N_TRITS; i < 2*N_TRITS; i++)
      pos_s = (wide_s[2*i +: 2] != T_ZERO) ? (wide_s[2*i +: 2] == T_POS) : pos_s;
    res_s = ovf_s ? (pos_s ? {N_TRITS{T_POS}} : {N_TRITS{T_NEG}}) : wide_s[W-1:0];
`else
    res_s = wide_s[W-1:0];
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE:    state_next = in_valid ? ((op == OP_MUL) ? MUL_RUN : DONE) : IDLE;
      MUL_RUN: state_next = (step_r == LAST_STEP) ? DONE : MUL_RUN;
      DONE:    state_next = out_ready ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, trit-serial multiply, result and accumulator registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pp_r        <= ZERO_2N;
      xs_r        <= ZERO_2N;
      y_r         <= ZERO_N;
      acc_r       <= ZERO_N;
      res_r       <= ZERO_N;
      step_r      <= 5'd0;
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            xs_r   <= {ZERO_N, x};
            y_r    <= y;
            pp_r   <= ZERO_2N;
            step_r <= 5'd0;
            if (op != OP_MUL) begin
              res_r       <= res_s;
              ovf_r       <= ovf_s;
              out_valid_r <= 1'b1;
            end else begin
              out_valid_r <= 1'b0;
            end
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        MUL_RUN: begin
          pp_r   <= wide_s;
          xs_r   <= {xs_r[W2-3:0], T_ZERO};
          y_r    <= {T_ZERO, y_r[W-1:2]};
          step_r <= step_r + 5'd1;
          if (step_r == LAST_STEP) begin
            res_r       <= res_s;
            ovf_r       <= ovf_s;
            out_valid_r <= 1'b1;
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            acc_r       <= res_r;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

endmodule
